// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: op encodings, state type, default latencies and the
// 64-bit {HI,LO} result function used at the start edge.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Returns {HI, LO}. Division corner cases are muxed ahead of the operators
  // so the result register never sees an undefined quotient.
  function automatic logic [63:0] mdu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic [63:0]        res;
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    squot = '0;
    srem  = '0;
    res   = '0;
    case (op)
      MDU_MULT:  res = sprod;
      MDU_MULTU: res = uprod;
      MDU_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          squot = $signed(a) / $signed(b);
          srem  = $signed(a) % $signed(b);
          res   = {srem, squot};
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; result is computed at the start
// edge and committed to HI/LO after MULT_CYCLES/DIV_CYCLES busy cycles.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUCtrl,
  input  logic        En,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  mdu_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [63:0]    result_q;
  logic [31:0]    hi_q, lo_q;
  logic           last_cycle;
  logic           idle_en;

  assign idle_en    = En && (state_q == MDU_IDLE);
  assign Start      = idle_en && is_long_op(MDUCtrl);
  assign Busy       = (state_q == MDU_RUN);
  assign last_cycle = (state_q == MDU_RUN) && (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (Start)      state_d = MDU_RUN;
      MDU_RUN:  if (last_cycle) state_d = MDU_IDLE;
      default:                  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (Start) begin
        result_q <= mdu_calc(MDUCtrl, SrcA, SrcB);
        cnt_q    <= is_div_op(MDUCtrl) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state_q == MDU_RUN) begin
        cnt_q <= cnt_q - CW'(1);
      end
      // Moves are only accepted while idle, so they never race a commit.
      if (last_cycle) begin
        hi_q <= result_q[63:32];
        lo_q <= result_q[31:0];
      end else if (idle_en && (MDUCtrl == MDU_MTHI)) begin
        hi_q <= SrcA;
      end else if (idle_en && (MDUCtrl == MDU_MTLO)) begin
        lo_q <= SrcA;
      end
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  always_comb begin
    MDUOut = 32'd0;
    if (MDUCtrl == MDU_MFHI)      MDUOut = hi_q;
    else if (MDUCtrl == MDU_MFLO) MDUOut = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected {HI,LO,busy cycles}
// into a scoreboard; a negedge monitor pops and checks when Busy falls.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUCtrl;
  logic        En;
  logic [31:0] SrcA, SrcB;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDUOut;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  bit   busy_prev = 1'b0;
  int   busy_run = 0;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                         OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .MDUCtrl(MDUCtrl),
    .En     (En),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Start  (Start),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .MDUOut (MDUOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO on each falling edge of Busy.
  always @(negedge clk) begin
    if (mon_en) begin
      if (Busy) busy_run++;
      if (busy_prev && !Busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: got HI=%h LO=%h with empty scoreboard", HI, LO);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_hi", HI, e.hi);
          check("sb_lo", LO, e.lo);
          check("sb_busy_cycles", 32'(busy_run), 32'(e.cycles));
        end
        busy_run = 0;
      end
      busy_prev = Busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (Busy) check("busy_timeout", 32'(Busy), 32'd0);
  endtask

  // Issues one long op from just after a posedge, then scrambles operands.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.cycles = cyc;
    sb.push_back(e);
    En = 1'b1;
    MDUCtrl = op;
    SrcA = a;
    SrcB = b;
    #1;
    check("start_asserted", 32'(Start), 32'd1);
    @(posedge clk);
    #1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
    SrcA = $urandom;
    SrcB = $urandom;
    wait_idle();
  endtask

  task automatic idle_op(input logic [3:0] op, input logic en_v, input logic [31:0] a);
    En = en_v;
    MDUCtrl = op;
    SrcA = a;
    @(posedge clk);
    #1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
    SrcA = '0;
    SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_start", 32'(Start), 32'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 5);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 5);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(OP_DIV,   32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 10);
    run_op(OP_DIVU,  32'h7, 32'h2, 32'h1, 32'h3, 10);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 10);
    run_op(OP_DIV,   32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 10);
    run_op(OP_DIVU,  32'h9, 32'h0, 32'h9, 32'hFFFF_FFFF, 10);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);

    // Moves and reads while idle
    idle_op(OP_MTHI, 1'b1, 32'h0000_AAAA);
    check("mthi_idle", HI, 32'h0000_AAAA);
    idle_op(OP_MTLO, 1'b1, 32'h0000_5555);
    check("mtlo_idle", LO, 32'h0000_5555);
    idle_op(OP_MTHI, 1'b0, 32'hDEAD_BEEF);
    check("mthi_en0", HI, 32'h0000_AAAA);
    MDUCtrl = OP_MFHI;
    #1;
    check("mfhi_out", MDUOut, 32'h0000_AAAA);
    MDUCtrl = OP_MFLO;
    #1;
    check("mflo_out", MDUOut, 32'h0000_5555);
    En = 1'b1;
    MDUCtrl = 4'd9;
    SrcA = 32'h1111_1111;
    SrcB = 32'h2;
    #1;
    check("undef_start", 32'(Start), 32'd0);
    check("undef_out", MDUOut, 32'd0);
    @(posedge clk);
    #1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
    check("undef_busy", 32'(Busy), 32'd0);
    check("undef_hi", HI, 32'h0000_AAAA);
    check("undef_lo", LO, 32'h0000_5555);

    // Ops presented while busy are dropped
    begin
      exp_t e;
      e.hi = 32'h0;
      e.lo = 32'h100;
      e.cycles = 5;
      sb.push_back(e);
    end
    En = 1'b1;
    MDUCtrl = OP_MULT;
    SrcA = 32'h10;
    SrcB = 32'h10;
    @(posedge clk);
    #1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
    @(posedge clk);
    #1;
    En = 1'b1;
    MDUCtrl = OP_MTHI;
    SrcA = 32'h1234;
    #1;
    check("busy_mthi_start", 32'(Start), 32'd0);
    @(posedge clk);
    #1;
    MDUCtrl = OP_MULT;
    SrcA = 32'h5;
    SrcB = 32'h5;
    #1;
    check("busy_mult_start", 32'(Start), 32'd0);
    @(posedge clk);
    #1;
    MDUCtrl = OP_MFHI;
    #1;
    check("busy_mfhi_old", MDUOut, 32'h0000_AAAA);
    En = 1'b0;
    MDUCtrl = OP_NONE;
    wait_idle();
    @(negedge clk);
    check("busy_drop_hi", HI, 32'h0);

    // Reset during cycle 3 of a divide aborts without committing
    @(posedge clk);
    #1;
    idle_op(OP_MTHI, 1'b1, 32'h0000_7777);
    begin
      exp_t e;
      e.hi = 32'h0;
      e.lo = 32'h0;
      e.cycles = 3;
      sb.push_back(e);
    end
    En = 1'b1;
    MDUCtrl = OP_DIV;
    SrcA = 32'd100;
    SrcB = 32'd7;
    @(posedge clk);
    #1;
    En = 1'b0;
    MDUCtrl = OP_NONE;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_commit_hi", HI, 32'd0);
    check("abort_no_commit_lo", LO, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
